// File: rtl/sram_unit_access_ctrl.sv
// Sub-word access sequencer for one 8-bit SRAM unit: drives the input-shifter size
// selects and lane write mask for writes, and right-aligns extracted fields for reads.
module sram_unit_access_ctrl #(
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [7:0]        resp_rdata,
  output logic              resp_err,
  output logic              c8,
  output logic              c4,
  output logic              c2,
  output logic              c1,
  output logic [7:0]        d_in,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-4:0] sram_addr,
  output logic [7:0]        sram_wmask,
  input  logic [7:0]        sram_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0] state_r;
  logic       we_r;
  logic [1:0] size_r;
  logic [2:0] off_r;
  logic [2:0] cnt_r;

  logic       accept_s;
  logic       misalign_s;
  logic [7:0] req_wmask_s;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // A field must start on a multiple of its own width inside the byte.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic mis;
    case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = off[0];
      2'd2:    mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] size_onehot(input logic [1:0] size);
    logic [3:0] oh;
    case (size)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      default: oh = 4'b1000;
    endcase
    return oh;
  endfunction

  function automatic logic [7:0] extract_field(input logic [7:0] data, input logic [1:0] size,
                                               input logic [2:0] off);
    logic [7:0] sh;
    sh = data >> off;
    return sh & size_mask(size);
  endfunction

  // Request decode for the accept cycle
  always_comb begin
    accept_s    = req_valid & req_ready & (state_r == ST_IDLE);
    misalign_s  = is_misaligned(req_size, req_addr[2:0]);
    if (req_we) begin
      req_wmask_s = size_mask(req_size) << req_addr[2:0];
    end else begin
      req_wmask_s = 8'h00;
    end
  end

  // Access sequencer with all outputs registered; SRAM strobes default to a single-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      we_r       <= 1'b0;
      size_r     <= 2'd0;
      off_r      <= 3'd0;
      cnt_r      <= 3'd0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 8'h00;
      {c8, c4, c2, c1} <= 4'b0000;
      d_in       <= 8'h00;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wmask <= 8'h00;
    end else begin
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_wmask <= 8'h00;
      req_ready  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            we_r       <= req_we;
            size_r     <= req_size;
            off_r      <= req_addr[2:0];
            {c8, c4, c2, c1} <= size_onehot(req_size);
            d_in       <= req_wdata;
            resp_rdata <= 8'h00;
            if (misalign_s) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              state_r    <= ST_RESP;
            end else begin
              sram_en    <= 1'b1;
              sram_we    <= req_we;
              sram_addr  <= req_addr[ADDR_W-1:3];
              sram_wmask <= req_wmask_s;
              resp_err   <= 1'b0;
              state_r    <= ST_ISSUE;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (we_r) begin
            resp_valid <= 1'b1;
            resp_rdata <= 8'h00;
            state_r    <= ST_RESP;
          end else begin
            cnt_r   <= 3'(RD_LAT - 1);
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Macro data is valid in the final wait cycle only.
          if (cnt_r == 3'd0) begin
            resp_rdata <= extract_field(sram_rdata, size_r, off_r);
            resp_valid <= 1'b1;
            state_r    <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 8'h00;
            req_ready  <= 1'b1;
            state_r    <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
